// File: rtl/door_lock_supervisor.sv
// rtl/door_lock_supervisor.sv - keypad entry, checker handshake, result LEDs and lockout
//
// Collects a 3-digit keypad code between start and done edges and replays it
// to the external code checker as start / 3 digits / done on consecutive
// cycles. It then shows pass/fail on the LEDs for LED_ON_PERIOD cycles and
// counts consecutive failures. Reaching MAX_FAIL failures locks the block for
// LOCKOUT_CYCLES cycles.
//
// Optional feature: define DOOR_LOCK_TIMEOUT_EN to fail an entry that sees
// no accepted press and no done for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, done_i   entry begin/end, rising edge used
//   button_i[9:0]     keypad, one bit per digit 0..9
//   chk_start_o       one-cycle pulse opening a check transaction
//   chk_digit_vld_o   chk_digit_o valid this cycle
//   chk_digit_o[3:0]  binary digit 0..9
//   chk_done_o        one-cycle pulse closing the transaction
//   chk_res_vld_i     checker result strobe
//   chk_pass_i        checker verdict, sampled with chk_res_vld_i
//   led_o[1:0]        00 off, 01 pass, 10 fail, 11 locked
//   locked_o          lockout active
//   fail_cnt_o[2:0]   consecutive failure count
module door_lock_supervisor #(
  parameter int LED_ON_PERIOD  = 300,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       done_i,
  input  logic [9:0] button_i,
  output logic       chk_start_o,
  output logic       chk_digit_vld_o,
  output logic [3:0] chk_digit_o,
  output logic       chk_done_o,
  input  logic       chk_res_vld_i,
  input  logic       chk_pass_i,
  output logic [1:0] led_o,
  output logic       locked_o,
  output logic [2:0] fail_cnt_o
);

  // One shared timer serves the LED period, the lockout and the entry timeout.
  localparam int MAX_A = (LED_ON_PERIOD > LOCKOUT_CYCLES) ? LED_ON_PERIOD : LOCKOUT_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    IDLE, ENTRY, SUBMIT, WAIT_RES, PASS, FAIL, LOCKOUT
  } state_t;

  state_t          state_q;
  logic            start_q, done_q;
  logic [9:0]      btn_q;
  logic [1:0]      cnt_q;
  logic [2:0][3:0] slot_q;
  logic [2:0]      sub_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      fail_cnt_q;
  logic            chk_start_q, chk_vld_q, chk_done_q, locked_q;
  logic [3:0]      chk_digit_q;
  logic [1:0]      led_q;

  logic       start_rise, done_rise, btn_onehot, press, press_ok;
  logic [3:0] digit;
  logic [1:0] cnt_after;
  logic [2:0] fail_next;

  always_comb begin
    start_rise = start_i & ~start_q;
    done_rise  = done_i & ~done_q;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    btn_onehot = (button_i != 10'd0) && ((button_i & (button_i - 10'd1)) == 10'd0);
    press      = btn_onehot && (btn_q == 10'd0);
    press_ok   = press && (cnt_q != 2'd3);
    // A press in the same cycle as done is counted before cnt is judged.
    cnt_after  = press_ok ? cnt_q + 2'd1 : cnt_q;
    fail_next  = (fail_cnt_q == 3'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 3'd1;
    digit      = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (button_i[i]) digit = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      btn_q       <= 10'd0;
      cnt_q       <= 2'd0;
      slot_q      <= '0;
      sub_q       <= 3'd0;
      timer_q     <= '0;
      fail_cnt_q  <= 3'd0;
      chk_start_q <= 1'b0;
      chk_vld_q   <= 1'b0;
      chk_digit_q <= 4'd0;
      chk_done_q  <= 1'b0;
      led_q       <= 2'b00;
      locked_q    <= 1'b0;
    end else begin
      start_q <= start_i;
      done_q  <= done_i;
      btn_q   <= button_i;
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q <= ENTRY;
            cnt_q   <= 2'd0;
            timer_q <= '0;
          end
        end
        ENTRY: begin
          if (start_rise) begin
            cnt_q   <= 2'd0;
            timer_q <= '0;
          end else begin
            if (press_ok) begin
              case (cnt_q)
                2'd0:    slot_q[0] <= digit;
                2'd1:    slot_q[1] <= digit;
                default: slot_q[2] <= digit;
              endcase
              cnt_q <= cnt_after;
            end
            if (done_rise) begin
              if (cnt_after == 2'd3) begin
                state_q     <= SUBMIT;
                sub_q       <= 3'd0;
                chk_start_q <= 1'b1;
              end else begin
                state_q    <= FAIL;
                led_q      <= 2'b10;
                timer_q    <= '0;
                fail_cnt_q <= fail_next;
              end
            end
`ifdef DOOR_LOCK_TIMEOUT_EN
            else if (press_ok) begin
              timer_q <= '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q    <= FAIL;
              led_q      <= 2'b10;
              timer_q    <= '0;
              fail_cnt_q <= fail_next;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
`endif
          end
        end
        SUBMIT: begin
          // Outputs are registered, so step k sets what is shown in step k+1.
          sub_q <= sub_q + 3'd1;
          case (sub_q)
            3'd0: begin
              chk_start_q <= 1'b0;
              chk_vld_q   <= 1'b1;
              chk_digit_q <= slot_q[0];
            end
            3'd1: chk_digit_q <= slot_q[1];
            3'd2: chk_digit_q <= slot_q[2];
            3'd3: begin
              chk_vld_q   <= 1'b0;
              chk_digit_q <= 4'd0;
              chk_done_q  <= 1'b1;
            end
            default: begin
              chk_done_q <= 1'b0;
              state_q    <= WAIT_RES;
            end
          endcase
        end
        WAIT_RES: begin
          if (chk_res_vld_i) begin
            timer_q <= '0;
            if (chk_pass_i) begin
              state_q    <= PASS;
              led_q      <= 2'b01;
              fail_cnt_q <= 3'd0;
            end else begin
              state_q    <= FAIL;
              led_q      <= 2'b10;
              fail_cnt_q <= fail_next;
            end
          end
        end
        PASS: begin
          if (timer_q == TW'(LED_ON_PERIOD - 1)) begin
            state_q <= IDLE;
            led_q   <= 2'b00;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        FAIL: begin
          if (timer_q == TW'(LED_ON_PERIOD - 1)) begin
            timer_q <= '0;
            if (fail_cnt_q == 3'(MAX_FAIL)) begin
              state_q  <= LOCKOUT;
              led_q    <= 2'b11;
              locked_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              led_q   <= 2'b00;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
            state_q    <= IDLE;
            led_q      <= 2'b00;
            locked_q   <= 1'b0;
            fail_cnt_q <= 3'd0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_start_o     = chk_start_q;
  assign chk_digit_vld_o = chk_vld_q;
  assign chk_digit_o     = chk_digit_q;
  assign chk_done_o      = chk_done_q;
  assign led_o           = led_q;
  assign locked_o        = locked_q;
  assign fail_cnt_o      = fail_cnt_q;

endmodule

// File: tb/tb_door_lock_supervisor.sv
// tb/tb_door_lock_supervisor.sv - vector-table and sequence bench for door_lock_supervisor
module tb_door_lock_supervisor;

  localparam int LED_P  = 300;
  localparam int LOCK_P = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, done_i = 1'b0;
  logic [9:0] button_i = 10'd0;
  logic       chk_start_o, chk_digit_vld_o, chk_done_o;
  logic [3:0] chk_digit_o;
  logic       chk_res_vld_i = 1'b0, chk_pass_i = 1'b0;
  logic [1:0] led_o;
  logic       locked_o;
  logic [2:0] fail_cnt_o;

  door_lock_supervisor dut (
    .clk(clk), .rst(rst), .start_i(start_i), .done_i(done_i), .button_i(button_i),
    .chk_start_o(chk_start_o), .chk_digit_vld_o(chk_digit_vld_o),
    .chk_digit_o(chk_digit_o), .chk_done_o(chk_done_o),
    .chk_res_vld_i(chk_res_vld_i), .chk_pass_i(chk_pass_i),
    .led_o(led_o), .locked_o(locked_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Every cycle with any checker-bus activity: {start, vld, digit, done}.
  logic [6:0] mon_v[$];
  int         mon_t[$];
  always @(negedge clk) begin
    if (chk_start_o || chk_digit_vld_o || chk_done_o) begin
      mon_v.push_back({chk_start_o, chk_digit_vld_o, chk_digit_o, chk_done_o});
      mon_t.push_back(cyc);
    end
  end

  typedef struct {
    int              np;
    logic [3:0][9:0] pr;
    logic            pass;
    logic            sub;
    logic [2:0][3:0] d;
    logic [1:0]      led;
    logic [2:0]      fc;
  } vec_t;
  vec_t vt[12];

  function automatic logic [9:0] k(input int d);
    return 10'd1 << d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input int np, input logic [9:0] p0, p1, p2, p3,
                         input logic pass, sub, input logic [3:0] d0, d1, d2,
                         input logic [1:0] led, input logic [2:0] fc);
    vt[i].np = np;
    vt[i].pr = {p3, p2, p1, p0};
    vt[i].pass = pass;
    vt[i].sub = sub;
    vt[i].d = {d2, d1, d0};
    vt[i].led = led;
    vt[i].fc = fc;
  endtask

  task automatic press(input logic [9:0] b);
    button_i = b;
    step();
    button_i = 10'd0;
    step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  task automatic check_chk(input logic [3:0] d0, d1, d2);
    logic [6:0] e[5];
    e[0] = 7'b1000000;
    e[1] = {2'b01, d0, 1'b0};
    e[2] = {2'b01, d1, 1'b0};
    e[3] = {2'b01, d2, 1'b0};
    e[4] = 7'b0000001;
    chk("chk_beats", mon_v.size(), 5);
    if (mon_v.size() >= 5) begin
      for (int j = 0; j < 5; j++) begin
        chk($sformatf("chk_beat%0d", j), {25'd0, mon_v[j]}, {25'd0, e[j]});
        chk($sformatf("chk_gap%0d", j), mon_t[j] - mon_t[0], j);
      end
    end
  endtask

  task automatic respond(input logic p);
    chk_pass_i = p;
    chk_res_vld_i = 1'b1;
    step();
    chk_res_vld_i = 1'b0;
    chk_pass_i = 1'b0;
  endtask

  task automatic measure_led(input logic [1:0] exp, input logic [2:0] fc, input logic [1:0] after);
    int w = 0;
    int n = 0;
    while (led_o == 2'b00 && w < 50) begin
      step();
      w++;
    end
    chk("fail_cnt", fail_cnt_o, fc);
    while (led_o == exp && n < 2000) begin
      n++;
      step();
    end
    chk("led_period", n, LED_P);
    chk("led_after", led_o, after);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vt[i];
    mon_v.delete();
    mon_t.delete();
    pulse_start();
    for (int j = 0; j < v.np; j++) press(v.pr[j]);
    pulse_done();
    if (v.sub) begin
      repeat (8) step();
      check_chk(v.d[0], v.d[1], v.d[2]);
      respond(v.pass);
    end
    measure_led(v.led, v.fc, (v.fc == 3'd3) ? 2'b11 : 2'b00);
    chk($sformatf("vec%0d_beats", i), mon_v.size(), v.sub ? 5 : 0);
  endtask

  initial begin
    int n;
    int bad;
    //          i  np  p0       p1    p2    p3    pass sub d0 d1 d2 led    fc
    set_vec(0,  3, k(8),    k(4), k(0), 10'd0, 1, 1, 8, 4, 0, 2'b01, 0);
    set_vec(1,  3, k(1),    k(4), k(3), 10'd0, 0, 1, 1, 4, 3, 2'b10, 1);
    set_vec(2,  3, k(8),    k(4), k(0), 10'd0, 1, 1, 8, 4, 0, 2'b01, 0);
    set_vec(3,  2, k(5),    k(2), 10'd0, 10'd0, 0, 0, 0, 0, 0, 2'b10, 1);
    set_vec(4,  4, 10'b11,  k(7), k(1), k(2),  1, 1, 7, 1, 2, 2'b01, 0);
    set_vec(5,  4, k(8),    k(4), k(0), k(7),  0, 1, 8, 4, 0, 2'b10, 1);
    set_vec(6,  3, k(9),    k(9), k(9), 10'd0, 1, 1, 9, 9, 9, 2'b01, 0);
    set_vec(7,  3, k(1),    k(4), k(3), 10'd0, 0, 1, 1, 4, 3, 2'b10, 1);
    set_vec(8,  3, k(1),    k(4), k(3), 10'd0, 0, 1, 1, 4, 3, 2'b10, 2);
    set_vec(9,  3, k(1),    k(4), k(3), 10'd0, 0, 1, 1, 4, 3, 2'b10, 3);
    set_vec(10, 3, k(8),    k(4), k(0), 10'd0, 1, 1, 8, 4, 0, 2'b01, 0);

    repeat (3) step();
    chk("rst_chk_start", chk_start_o, 0);
    rst = 1'b0;
    step();
    chk("reset_led", led_o, 0);
    chk("reset_locked", locked_o, 0);
    chk("reset_fail_cnt", fail_cnt_o, 0);
    chk("reset_chk_bus", {chk_start_o, chk_digit_vld_o, chk_digit_o, chk_done_o}, 0);

    for (int i = 0; i <= 6; i++) run_vec(i);

    // Three checker fails in a row lock the block.
    for (int i = 7; i <= 9; i++) run_vec(i);
    mon_v.delete();
    mon_t.delete();
    n = 0;
    while (led_o == 2'b11 && locked_o && n < 3000) begin
      start_i  = (n == 10);
      button_i = (n == 20 || n == 40) ? k(2) : 10'd0;
      done_i   = (n == 60);
      n++;
      step();
    end
    start_i = 1'b0;
    button_i = 10'd0;
    done_i = 1'b0;
    chk("lockout_period", n, LOCK_P);
    chk("lockout_no_chk", mon_v.size(), 0);
    chk("lockout_exit_fc", fail_cnt_o, 0);
    chk("lockout_exit_led", led_o, 0);
    chk("lockout_exit_locked", locked_o, 0);
    run_vec(10);

    // Restart mid-entry discards the digit pressed before it.
    pulse_start();
    press(k(9));
    run_vec(10);

    // Press and done in the same cycle: the press completes the code.
    mon_v.delete();
    mon_t.delete();
    pulse_start();
    press(k(1));
    press(k(2));
    button_i = k(3);
    done_i = 1'b1;
    step();
    button_i = 10'd0;
    done_i = 1'b0;
    repeat (8) step();
    check_chk(1, 2, 3);
    respond(1'b1);
    measure_led(2'b01, 0, 2'b00);

    // Reset while waiting for the checker; a late result is ignored.
    run_vec(7);
    pulse_start();
    press(k(8));
    press(k(4));
    press(k(0));
    pulse_done();
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_led", led_o, 0);
    chk("midrst_fail_cnt", fail_cnt_o, 0);
    chk("midrst_locked", locked_o, 0);
    chk("midrst_chk_bus", {chk_start_o, chk_digit_vld_o, chk_digit_o, chk_done_o}, 0);
    respond(1'b1);
    bad = 0;
    repeat (20) begin
      step();
      if (led_o != 2'b00) bad++;
    end
    chk("late_res_led", bad, 0);

`ifdef DOOR_LOCK_TIMEOUT_EN
    start_i = 1'b1;
    n = 0;
    while (led_o != 2'b10 && n < 1000) begin
      step();
      n++;
    end
    start_i = 1'b0;
    chk("timeout_fail", (n >= 500 && n <= 502), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
